// File: rtl/alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// alu_exec_ctrl
//
// Purpose: sequences one instruction at a time through an external ALU.
// An accepted instruction word is registered and decoded into ALU control
// fields. Its condition code is tested against the architectural flags.
// The controller waits the multiply latency when needed, captures the ALU
// result and flags, and offers the result on a valid/ready writeback port.
// Completed instructions are counted in a wrapping 16-bit counter.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   instr[31:0]              {cond, opcode, S, SR_Cont, Rd, Immediate}
//   alu_opcode/alu_sr_cont/alu_sr_bit/alu_s/alu_imm   ALU controls
//   alu_out, alu_flags       ALU result and {N,Z,C,V}
//   wb_valid/wb_ready        writeback handshake
//   wb_addr, wb_data         writeback destination and value
//   flags                    architectural {N,Z,C,V}
//   illegal                  one-cycle pulse for an executed illegal opcode
//   retired_cnt              completed-instruction count
//
// Parameter:
//   MUL_LAT  total ALU cycles a multiply needs (1..15)
// ---------------------------------------------------------------------------
module alu_exec_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  alu_opcode,
  output logic [2:0]  alu_sr_cont,
  output logic [4:0]  alu_sr_bit,
  output logic        alu_s,
  output logic [15:0] alu_imm,
  input  logic [31:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [3:0]  flags,
  output logic        illegal,
  output logic [15:0] retired_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, MULW, WB} state_t;

  localparam logic [3:0] MUL_LOAD  = 4'(MUL_LAT - 1);
  localparam bit         MUL_MULTI = (MUL_LAT > 1);

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0]  mul_cnt_q, mul_cnt_d;
  logic [3:0]  flags_q, flags_d;
  logic        wb_valid_q, wb_valid_d;
  logic [3:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [15:0] retired_cnt_q, retired_cnt_d;

  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        is_cmp;
  logic        is_mul;
  logic        is_illegal_op;
  logic        cond_true;
  logic        capture;
  logic        illegal_pulse;

  assign cond          = instr_q[31:28];
  assign opcode        = instr_q[27:24];
  assign is_cmp        = (opcode == 4'b1000);
  assign is_mul        = (opcode == 4'b0010);
  assign is_illegal_op = (opcode >= 4'b1001);

  // The ALU controls come only from the registered instruction. That
  // register changes only on accept, so the controls stay stable through
  // execution and keep their last value while idle. CMP is presented to
  // the ALU as a flag-setting subtract (opcode 0001 with S forced on).
  assign alu_opcode  = is_cmp ? 4'b0001 : opcode;
  assign alu_s       = is_cmp | instr_q[23];
  assign alu_sr_cont = instr_q[22:20];
  assign alu_sr_bit  = instr_q[4:0];
  assign alu_imm     = instr_q[15:0];

  // The ready and illegal outputs are gated with reset so that nothing
  // appears accepted or flagged while reset is held, even though the state
  // register only clears on the next edge.
  assign instr_ready = (state_q == IDLE) & ~rst;
  assign illegal     = illegal_pulse & ~rst;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign flags       = flags_q;
  assign retired_cnt = retired_cnt_q;

  // Condition evaluation against the current architectural flags
  // {N,Z,C,V}. Codes 1000-1101 and 1111 are never taken.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'b0000: cond_true = flags_q[2];
      4'b0001: cond_true = ~flags_q[2];
      4'b0010: cond_true = flags_q[1];
      4'b0011: cond_true = ~flags_q[1];
      4'b0100: cond_true = flags_q[3];
      4'b0101: cond_true = ~flags_q[3];
      4'b0110: cond_true = flags_q[0];
      4'b0111: cond_true = ~flags_q[0];
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state logic. The per-state case decides when the ALU result is
  // captured. The capture block after it then applies the flag update and
  // either retires a CMP directly or moves the result into writeback. A
  // multiply with more than one cycle of latency waits in MULW on a
  // down-counter and captures on the cycle the counter reads 1.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    mul_cnt_d     = mul_cnt_q;
    flags_d       = flags_q;
    wb_valid_d    = wb_valid_q;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    retired_cnt_d = retired_cnt_q;
    illegal_pulse = 1'b0;
    capture       = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!cond_true) begin
          state_d = IDLE;
        end else if (is_illegal_op) begin
          illegal_pulse = 1'b1;
          state_d       = IDLE;
        end else if (is_mul && MUL_MULTI) begin
          mul_cnt_d = MUL_LOAD;
          state_d   = MULW;
        end else begin
          capture = 1'b1;
        end
      end
      MULW: begin
        if (mul_cnt_q == 4'd1) begin
          capture   = 1'b1;
          mul_cnt_d = 4'd0;
        end else begin
          mul_cnt_d = mul_cnt_q - 4'd1;
        end
      end
      WB: begin
        if (wb_ready) begin
          wb_valid_d    = 1'b0;
          retired_cnt_d = retired_cnt_q + 16'd1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      if (alu_s) begin
        flags_d = alu_flags;
      end
      if (is_cmp) begin
        retired_cnt_d = retired_cnt_q + 16'd1;
        state_d       = IDLE;
      end else begin
        wb_data_d  = alu_out;
        wb_addr_d  = instr_q[19:16];
        wb_valid_d = 1'b1;
        state_d    = WB;
      end
    end
  end

  // State register. Reset abandons any instruction in flight and clears
  // every piece of architectural and pipeline state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      mul_cnt_q     <= '0;
      flags_q       <= '0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      mul_cnt_q     <= mul_cnt_d;
      flags_q       <= flags_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

endmodule
